uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte-buffering front end for the UART transmitter in `uart_RT`. It sits directly upstream of the transmitter and accepts bytes from a host-side producer into a small FIFO. It drains the bytes one at a time into the transmitter's `Tx_DATA`/`Tx_WR` inputs, pacing itself on `Tx_BUSY`. Producers can therefore write bursts without tracking the serial line state.

## Interface
- `DEPTH`, 8, FIFO depth in bytes; power of two, ≥ 2.
- `ADDR_W`, 3, log2(`DEPTH`).
- `ACK_TIMEOUT`, 16, cycles to wait for `Tx_BUSY` to rise after a `Tx_WR` pulse.

Ports:
- `clk`  in  1  system clock (50 MHz in the system bench).
- `reset`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue request, sampled on the rising edge of `clk`.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  ADDR_W+1  number of bytes stored, 0..`DEPTH`.
- `overflow`  out  1  sticky; set when a push is attempted while full.
- `ack_err`  out  1  sticky; set when `Tx_BUSY` fails to rise within `ACK_TIMEOUT` cycles.
- `Tx_DATA`  out  8  byte presented to the transmitter.
- `Tx_WR`  out  1  one-cycle write strobe to the transmitter.
- `Tx_BUSY`  in  1  transmitter busy flag.

## Operation
- FIFO: `DEPTH`×8 register array with `ADDR_W`-bit read and write pointers that wrap modulo `DEPTH`. `count` is an explicit register; `full` = (`count`==`DEPTH`) and `empty` = (`count`==0), both registered or decoded from `count`.
- Push: accepted when `wr_en`=1 and `full`=0 at the edge. The byte is stored at the write pointer, which then increments. When `wr_en`=1 and `full`=1, the byte is dropped, `overflow` is set to 1, and FIFO state is unchanged.
- Pop: occurs only on the IDLE→LOAD transition.
- A simultaneous accepted push and pop leaves `count` unchanged. There is no bypass: a byte pushed into an empty FIFO is not poppable in the same cycle.
- FSM states:
  - IDLE: if `empty`=0 and `Tx_BUSY`=0, go to LOAD, latch `Tx_DATA` ← mem[rd_ptr], and increment rd_ptr. Otherwise stay.
  - LOAD: `Tx_WR`=1 for exactly this one cycle. Go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: if `Tx_BUSY`=1, go to WAIT_DONE. Otherwise increment the timeout counter. When the counter reaches `ACK_TIMEOUT`, set `ack_err`=1 and return to IDLE; the byte is considered consumed and is not retried.
  - WAIT_DONE: if `Tx_BUSY`=0, go to IDLE.
- `Tx_DATA` holds its value from LOAD until the next LOAD. It changes only on the IDLE→LOAD edge.
- `overflow` and `ack_err` clear only on `reset`.

## Timing
- Reset values: `Tx_DATA`=8'h00, `Tx_WR`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `ack_err`=0, both pointers 0, state IDLE. Reset applies immediately on assertion, independent of `clk`.
- Latency, empty FIFO with idle transmitter:
  - edge N samples `wr_en`=1 → `empty`=0 after edge N;
  - edge N+1 moves IDLE→LOAD;
  - `Tx_WR`=1 during cycle N+1..N+2, i.e. 2 edges after the push.
- `Tx_WR` is a registered output. It is never high on two consecutive cycles.
- Back-to-back bytes: the next LOAD occurs 1 cycle after `Tx_BUSY` is sampled low in WAIT_DONE, then IDLE→LOAD on the following edge. Minimum gap is 2 cycles after `Tx_BUSY` falls.
- If `Tx_BUSY` is already 1 in IDLE, no pop occurs.
- Reset mid-transfer: the FIFO contents are discarded and `Tx_WR` drops asynchronously. A serial frame already started in `uart_RT` is not affected by this block.
- Pointer wrap: after `DEPTH` pushes and pops, both pointers return to 0 with no loss of ordering.

## Test plan
- Single byte: with `uart_RT` connected in loopback, `baud_select`=3'b100, `Tx_EN`=`Rx_EN`=1, push 8'h78 → one `Tx_WR` pulse 2 cycles later with `Tx_DATA`=8'h78. Later `Rx_VALID`=1, `Rx_DATA`=8'h78, and `Rx_PERROR`=`Rx_FERROR`=0.
- Burst/full: push 8'h01..8'h09 on 9 consecutive cycles with the transmitter stalled (`Tx_BUSY` forced 1):
  - `full`=1 after the 8th push;
  - `overflow`=1 after the 9th push;
  - after release, exactly 8'h01..8'h08 are emitted in order;
  - `count` returns to 0 and `empty`=1.
- Wrap-around: stream 20 bytes 8'hA0..8'hB3 through the loopback while keeping ≤ 8 outstanding → all 20 are received in order and `overflow` stays 0.
- Simultaneous push/pop: with `count`=3, push on the exact cycle of IDLE→LOAD → `count` stays 3 and the pushed byte is emitted fourth.
- Ack timeout: tie `Tx_BUSY`=0 and push 8'h55 →
  - `Tx_WR` pulses once;
  - `ack_err`=1 exactly 16 cycles after LOAD;
  - a second push 8'h66 still produces a `Tx_WR` pulse with `Tx_DATA`=8'h66.
- Reset mid-operation: push 4 bytes, assert `reset` during WAIT_DONE of the first byte →
  - all outputs return to their reset values immediately;
  - no further `Tx_WR` pulses occur after release until a new push.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that drains into a UART transmitter, paced by Tx_BUSY
module uart_tx_feeder #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              ack_err,
  output logic [7:0]        Tx_DATA,
  output logic              Tx_WR,
  input  logic              Tx_BUSY
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d, overflow_q, overflow_d, ack_err_q, ack_err_d;
  logic              push, pop;
  assign full     = count_q == (ADDR_W+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign ack_err  = ack_err_q;
  assign Tx_DATA  = tx_data_q;
  assign Tx_WR    = tx_wr_q;
  assign push     = wr_en && !full;
  // pop is decided from registered count, so a byte pushed this cycle is never bypassed
  assign pop      = state_q == IDLE && !empty && !Tx_BUSY;
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    count_d    = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    overflow_d = overflow_q | (wr_en & full);
    state_d    = state_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_wr_d    = 1'b0;
    ack_err_d  = ack_err_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d   = LOAD;
        tx_data_d = mem_q[rd_ptr_q];
        tx_wr_d   = 1'b1;
      end
      LOAD: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY: if (Tx_BUSY) state_d = WAIT_DONE;
      else begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TW'(ACK_TIMEOUT)) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_DONE: if (!Tx_BUSY) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: random and directed stimulus against a queue-based model of the feeder
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TMO   = 16;
  logic          clk = 1'b0, reset = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          full, empty, overflow, ack_err, tx_wr, tx_busy;
  logic [AW:0]   count;
  logic [7:0]    tx_data;
  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(AW), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .ack_err(ack_err),
    .Tx_DATA(tx_data), .Tx_WR(tx_wr), .Tx_BUSY(tx_busy)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, cyc = 0, last_fall = 0;
  logic [7:0] q[$];
  logic [7:0] em[$];
  logic ovf_m, ack_m, chk_ack = 1'b1, prev_wr, prev_busy;
  logic [7:0] prev_data;
  // transmitter stand-in: 0 = responds to Tx_WR with a busy window, 1 = stalled busy, 2 = never busy
  int mode = 0, busy_left, dur_lo = 1, dur_hi = 5;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      busy_left <= 0;
    end else if (mode == 1) tx_busy <= 1'b1;
    else if (mode == 2) tx_busy <= 1'b0;
    else if (tx_wr) begin
      tx_busy <= 1'b1;
      busy_left <= $urandom_range(dur_hi, dur_lo);
    end else if (busy_left > 1) busy_left <= busy_left - 1;
    else begin
      tx_busy <= 1'b0;
      busy_left <= 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else passed++;
  endtask
  task automatic cycle(input logic en, input logic [7:0] d);
    logic pre_full;
    wr_en = en;
    wr_data = d;
    pre_full = (q.size() == DEPTH);
    @(posedge clk); #1;
    cyc++;
    if (en) begin
      if (pre_full) ovf_m = 1'b1;
      else q.push_back(d);
    end
    check("wr_double", prev_wr & tx_wr, 0);
    if (tx_wr) begin
      check("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) check("tx_data", tx_data, q.pop_front());
      em.push_back(tx_data);
    end else check("data_hold", tx_data, prev_data);
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("overflow", overflow, ovf_m);
    if (chk_ack) check("ack_err", ack_err, ack_m);
    if (prev_busy && !tx_busy) last_fall = cyc;
    prev_wr = tx_wr;
    prev_data = tx_data;
    prev_busy = tx_busy;
  endtask
  task automatic check_reset_values(input string tag);
    check({tag, "_tx_wr"}, tx_wr, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_ack_err"}, ack_err, 0);
  endtask
  task automatic do_reset(input int m);
    mode = m;
    wr_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    em.delete();
    ovf_m = 1'b0;
    ack_m = 1'b0;
    chk_ack = 1'b1;
    prev_wr = 1'b0;
    prev_data = 8'h00;
    prev_busy = tx_busy;
  endtask
  initial begin
    int k;
    // single byte: Tx_WR two edges after the push
    do_reset(0);
    cycle(1, 8'h78);
    check("lat1_wr", tx_wr, 0);
    cycle(0, 0);
    check("lat2_wr", tx_wr, 1);
    check("lat2_data", tx_data, 8'h78);
    repeat (30) cycle(0, 0);
    check("single_em", em.size(), 1);
    // burst into a stalled transmitter, then drain
    do_reset(1);
    cycle(0, 0);
    for (int i = 1; i <= 9; i++) begin
      cycle(1, 8'(i));
      check("stall_nowr", tx_wr, 0);
      if (i == 8) check("full8", full, 1);
      if (i == 9) check("ovf9", overflow, 1);
    end
    mode = 0;
    repeat (120) begin
      cycle(0, 0);
      if (tx_wr && em.size() > 1) check("b2b_gap", cyc - last_fall, 2);
    end
    check("burst_em", em.size(), 8);
    for (int i = 0; i < 8 && i < em.size(); i++) check("burst_order", em[i], i + 1);
    check("burst_cnt", count, 0);
    check("burst_empty", empty, 1);
    // push on the exact IDLE->LOAD edge with three bytes queued
    do_reset(1);
    cycle(0, 0);
    cycle(1, 8'hA1);
    cycle(1, 8'hA2);
    cycle(1, 8'hA3);
    mode = 0;
    cycle(0, 0);
    cycle(1, 8'hC3);
    check("simul_wr", tx_wr, 1);
    check("simul_cnt", count, 3);
    repeat (80) cycle(0, 0);
    check("simul_em", em.size(), 4);
    if (em.size() == 4) check("simul_4th", em[3], 8'hC3);
    // acknowledge timeout: transmitter never raises busy
    do_reset(2);
    cycle(1, 8'h55);
    cycle(0, 0);
    check("tmo_wr", tx_wr, 1);
    chk_ack = 1'b0;
    k = 0;
    while (!ack_err && k < 40) begin
      cycle(0, 0);
      k++;
    end
    check("tmo_cycles", k, TMO + 1);
    check("tmo_pulses", em.size(), 1);
    ack_m = 1'b1;
    chk_ack = 1'b1;
    cycle(1, 8'h66);
    k = 0;
    while (!tx_wr && k < 10) begin
      cycle(0, 0);
      k++;
    end
    check("tmo_second_wr", tx_wr, 1);
    check("tmo_second_data", tx_data, 8'h66);
    repeat (40) cycle(0, 0);
    // reset while the first of four bytes is being sent
    do_reset(0);
    dur_lo = 12;
    dur_hi = 12;
    for (int i = 0; i < 4; i++) cycle(1, 8'hD0 + 8'(i));
    k = 0;
    while (!tx_busy && k < 20) begin
      cycle(0, 0);
      k++;
    end
    check("mid_busy", tx_busy, 1);
    cycle(0, 0);
    cycle(0, 0);
    check("mid_data", tx_data, 8'hD0);
    #2 reset = 1'b1;
    #1 check_reset_values("mid");
    do_reset(0);
    repeat (20) begin
      cycle(0, 0);
      check("mid_no_wr", tx_wr, 0);
    end
    // randomized traffic
    do_reset(0);
    dur_lo = 1;
    dur_hi = 5;
    repeat (400) cycle($urandom_range(0, 99) < 35, 8'($urandom));
    repeat (120) cycle(0, 0);
    check("rand_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
